// File: rtl/bsram_arbiter_pkg.sv
// Shared types for the two-requester BSRAM arbiter: sequencer states,
// requester ids and the read-return tag that follows each access through the RAM.
package bsram_arbiter_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_e;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef struct packed {
      logic valid;
      logic id;
   } rd_tag_t;

   localparam rd_tag_t TAG_NONE = '{valid: 1'b0, id: REQ_A};

   function automatic rd_tag_t make_tag(input logic valid, input logic id);
      rd_tag_t t;
      t.valid = valid;
      t.id    = id;
      return t;
   endfunction

endpackage

// File: rtl/bsram_arbiter_rr_arb2.sv
// Two-way round-robin grant. Grant is combinational; the priority pointer
// moves to the losing side after every grant so ties alternate.
module bsram_arbiter_rr_arb2
   import bsram_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   logic ptr_r;

   // Lone requester wins outright; the pointer only breaks ties.
   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (req_a && req_b) begin
         gnt_a = (ptr_r == REQ_A);
         gnt_b = (ptr_r == REQ_B);
      end else begin
         gnt_a = req_a;
         gnt_b = req_b;
      end
   end

   // Priority pointer register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_r <= REQ_A;
      end else if (gnt_a) begin
         ptr_r <= REQ_B;
      end else if (gnt_b) begin
         ptr_r <= REQ_A;
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/bsram_arbiter.sv
// Round-robin arbiter and sequencer in front of a single-port block RAM:
// zero-fills the RAM after reset, then serves one access per cycle from A or B.
module bsram_arbiter
   import bsram_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 13,
   parameter int DATA_W         = 8,
   parameter int RD_LAT         = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              a_valid,
   output logic              a_ready,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_rsp_valid,
   output logic [DATA_W-1:0] a_rdata,

   input  logic              b_valid,
   output logic              b_ready,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_rsp_valid,
   output logic [DATA_W-1:0] b_rdata,

   output logic              init_done,

   output logic              mem_ce,
   output logic              mem_oce,
   output logic              mem_reset,
   output logic              mem_wre,
   output logic [ADDR_W-1:0] mem_ad,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam int                DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

   state_e            state_r;
   logic [ADDR_W-1:0] clr_cnt_r;
   rd_tag_t           tag_r [RD_LAT];

   logic    run_s;
   logic    gnt_a_s;
   logic    gnt_b_s;
   rd_tag_t tag_in_s;
   rd_tag_t tag_out_s;

   // Requests are only visible to the arbiter once the sweep is over and reset is released.
   assign run_s = rst_n && (state_r == RUN);

   bsram_arbiter_rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .rst_n (rst_n),
      .req_a (a_valid && run_s),
      .req_b (b_valid && run_s),
      .gnt_a (gnt_a_s),
      .gnt_b (gnt_b_s)
   );

   // Sequencer: clear sweep over every address, then serve requests.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
         clr_cnt_r <= {ADDR_W{1'b0}};
      end else begin
         case (state_r)
            CLEAR: begin
               if (clr_cnt_r == CNT_LAST) begin
                  state_r   <= RUN;
                  clr_cnt_r <= clr_cnt_r;
               end else begin
                  state_r   <= CLEAR;
                  clr_cnt_r <= clr_cnt_r + CNT_ONE;
               end
            end
            RUN: begin
               state_r   <= RUN;
               clr_cnt_r <= clr_cnt_r;
            end
            default: begin
               state_r   <= CLEAR;
               clr_cnt_r <= {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // RAM command mux: sweep writes, granted requester, or idle.
   always_comb begin
      mem_ce  = 1'b0;
      mem_wre = 1'b0;
      mem_ad  = {ADDR_W{1'b0}};
      mem_din = {DATA_W{1'b0}};
      if (!rst_n) begin
         mem_ce  = 1'b0;
         mem_wre = 1'b0;
      end else if (state_r == CLEAR) begin
         mem_ce  = 1'b1;
         mem_wre = 1'b1;
         mem_ad  = clr_cnt_r;
         mem_din = {DATA_W{1'b0}};
      end else if (gnt_a_s) begin
         mem_ce  = 1'b1;
         mem_wre = a_we;
         mem_ad  = a_addr;
         mem_din = a_wdata;
      end else if (gnt_b_s) begin
         mem_ce  = 1'b1;
         mem_wre = b_we;
         mem_ad  = b_addr;
         mem_din = b_wdata;
      end else begin
         mem_ce  = 1'b0;
         mem_wre = 1'b0;
      end
   end

   // Tag for this cycle's access: only reads carry a valid owner id.
   always_comb begin
      tag_in_s = TAG_NONE;
      if (gnt_a_s) begin
         tag_in_s = make_tag(~a_we, REQ_A);
      end else if (gnt_b_s) begin
         tag_in_s = make_tag(~b_we, REQ_B);
      end else begin
         tag_in_s = TAG_NONE;
      end
   end

   // Tag pipeline matching the RAM read latency; reset drops reads in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            tag_r[i] <= TAG_NONE;
         end
      end else begin
         tag_r[0] <= tag_in_s;
         for (int i = 1; i < RD_LAT; i++) begin
            tag_r[i] <= tag_r[i-1];
         end
      end
   end

   assign tag_out_s = tag_r[RD_LAT-1];

   assign a_ready     = gnt_a_s;
   assign b_ready     = gnt_b_s;
   assign a_rsp_valid = rst_n && tag_out_s.valid && (tag_out_s.id == REQ_A);
   assign b_rsp_valid = rst_n && tag_out_s.valid && (tag_out_s.id == REQ_B);
   assign a_rdata     = mem_dout;
   assign b_rdata     = mem_dout;
   assign init_done   = run_s;
   assign mem_oce     = 1'b1;
   assign mem_reset   = ~rst_n;

endmodule

// File: tb/tb_bsram_arbiter.sv
// Scoreboard bench for bsram_arbiter: two instances (bypass and pipelined RAM
// read) share one stimulus stream; a negedge monitor checks every response.
module tb_bsram_arbiter;
   import bsram_arbiter_pkg::*;

   localparam int AW = 13;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n;
   logic a_valid, a_we, b_valid, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;

   logic d1_a_ready, d1_b_ready, d1_a_rsp, d1_b_rsp, d1_init;
   logic d1_ce, d1_oce, d1_rst, d1_wre;
   logic [AW-1:0] d1_ad;
   logic [DW-1:0] d1_din, d1_dout, d1_ard, d1_brd;

   logic d2_a_ready, d2_b_ready, d2_a_rsp, d2_b_rsp, d2_init;
   logic d2_ce, d2_oce, d2_rst, d2_wre;
   logic [AW-1:0] d2_ad;
   logic [DW-1:0] d2_din, d2_dout, d2_ard, d2_brd, q2a;

   logic [DW-1:0] mem1 [8192];
   logic [DW-1:0] mem2 [8192];
   logic filled = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic          id;
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   bsram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(d1_a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rsp_valid(d1_a_rsp), .a_rdata(d1_ard),
      .b_valid(b_valid), .b_ready(d1_b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rsp_valid(d1_b_rsp), .b_rdata(d1_brd),
      .init_done(d1_init), .mem_ce(d1_ce), .mem_oce(d1_oce), .mem_reset(d1_rst),
      .mem_wre(d1_wre), .mem_ad(d1_ad), .mem_din(d1_din), .mem_dout(d1_dout)
   );

   bsram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(d2_a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_rsp_valid(d2_a_rsp), .a_rdata(d2_ard),
      .b_valid(b_valid), .b_ready(d2_b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_rsp_valid(d2_b_rsp), .b_rdata(d2_brd),
      .init_done(d2_init), .mem_ce(d2_ce), .mem_oce(d2_oce), .mem_reset(d2_rst),
      .mem_wre(d2_wre), .mem_ad(d2_ad), .mem_din(d2_din), .mem_dout(d2_dout)
   );

   // RAM models: bypass read for dut1, extra output register for dut2; start non-zero.
   always @(posedge clk) begin
      if (!filled) begin
         for (int i = 0; i < 8192; i++) begin
            mem1[i] <= 8'hEE;
            mem2[i] <= 8'hEE;
         end
         filled <= 1'b1;
      end else begin
         if (d1_ce) begin
            if (d1_wre) mem1[d1_ad] <= d1_din;
            else        d1_dout     <= mem1[d1_ad];
         end
         if (d2_ce) begin
            if (d2_wre) mem2[d2_ad] <= d2_din;
            else        q2a         <= mem2[d2_ad];
         end
         if (d2_oce) d2_dout <= q2a;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic mon(input int k, input logic av, input logic bv,
                      input logic [DW-1:0] ad, input logic [DW-1:0] bd);
      exp_t e;
      logic [DW-1:0] got;
      if (av && bv) begin
         chk($sformatf("rsp_onehot_lat%0d", k), 32'd1, 32'd0);
      end else if (av || bv) begin
         if ((k == 1 && q1.size() == 0) || (k == 2 && q2.size() == 0)) begin
            chk($sformatf("rsp_unexpected_lat%0d", k), 32'd1, 32'd0);
         end else begin
            if (k == 1) e = q1.pop_front();
            else        e = q2.pop_front();
            got = av ? ad : bd;
            chk($sformatf("rsp_id_lat%0d", k), {31'd0, bv}, {31'd0, e.id});
            chk($sformatf("rsp_data_lat%0d", k), {24'd0, got}, {24'd0, e.data});
            chk($sformatf("rsp_cycle_lat%0d", k), cyc, e.cyc);
         end
      end
   endtask

   always @(negedge clk) begin
      mon(1, d1_a_rsp, d1_b_rsp, d1_ard, d1_brd);
      mon(2, d2_a_rsp, d2_b_rsp, d2_ard, d2_brd);
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      a_valid = 1'b0;
      b_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   // One cycle of stimulus; egnt = {A granted, B granted}, ed = expected read data.
   task automatic issue(input logic av, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] awd,
                        input logic bv, input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bwd,
                        input logic [1:0] egnt, input logic [DW-1:0] ed);
      exp_t e;
      a_valid = av; a_we = aw; a_addr = aa; a_wdata = awd;
      b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bwd;
      #1;
      chk("grant_lat1", {30'd0, d1_a_ready, d1_b_ready}, {30'd0, egnt});
      chk("grant_lat2", {30'd0, d2_a_ready, d2_b_ready}, {30'd0, egnt});
      if ((egnt[1] && !aw) || (egnt[0] && !bw)) begin
         e.id   = egnt[0];
         e.data = ed;
         e.cyc  = cyc + 1;
         q1.push_back(e);
         e.cyc  = cyc + 2;
         q2.push_back(e);
      end
      step();
   endtask

   // Releases a held reset and times the clear sweep; optionally re-resets at abort_at.
   task automatic sweep(input int abort_at);
      int n;
      bit aborted;
      aborted = 1'b0;
      rst_n   = 1'b1;
      a_valid = 1'b1; a_we = 1'b0;
      b_valid = 1'b1; b_we = 1'b0;
      #1;
      chk("clr_start_ad", {19'd0, d1_ad}, 32'd0);
      chk("clr_start_wr", {29'd0, d1_ce, d1_wre, d1_init}, 32'd6);
      n = 0;
      while (n < 9000 && !(d1_init && d2_init)) begin
         step();
         n++;
         if (n == 50) begin
            chk("clr_ready", {28'd0, d1_a_ready, d1_b_ready, d2_a_ready, d2_b_ready}, 32'd0);
            a_valid = 1'b0;
            b_valid = 1'b0;
         end
         if (n == abort_at && !aborted) begin
            aborted = 1'b1;
            chk("clr_mid_ad", {19'd0, d1_ad}, abort_at);
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            #1;
            chk("clr_restart_ad", {19'd0, d1_ad, d2_ad}, 32'd0);
            n = 0;
         end
      end
      chk("init_cycles", n, 32'd8192);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      rst_n = 1'b0;
      a_valid = 1'b1; a_we = 1'b0; a_addr = '0; a_wdata = '0;
      b_valid = 1'b1; b_we = 1'b0; b_addr = '0; b_wdata = '0;
      step();
      step();
      chk("rst_outs_lat1", {23'd0, d1_a_ready, d1_b_ready, d1_a_rsp, d1_b_rsp, d1_init,
                            d1_ce, d1_wre, d1_rst, d1_oce}, 32'h3);
      chk("rst_outs_lat2", {23'd0, d2_a_ready, d2_b_ready, d2_a_rsp, d2_b_rsp, d2_init,
                            d2_ce, d2_wre, d2_rst, d2_oce}, 32'h3);

      sweep(0);
      rst_n = 1'b0;
      step();
      sweep(100);

      // Top address after clear, then write-to-read forwarding across requesters.
      issue(1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h00);
      issue(1'b1, 1'b1, 13'h0123, 8'hA5, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h00);
      issue(1'b0, 1'b0, 13'h0000, 8'h00, 1'b0, 1'b0, 13'h0123, 8'h00, 2'b00, 8'h00);
      issue(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h0123, 8'h00, 2'b01, 8'hA5);
      idle(3);

      // Both requesters held valid: pointer is at A, so A,B,A,B,A,B.
      for (int i = 0; i < 6; i++) begin
         issue(1'b1, 1'b0, 13'h0123, 8'h00, 1'b1, 1'b0, 13'h1FFF, 8'h00,
               (i % 2 == 0) ? 2'b10 : 2'b01, (i % 2 == 0) ? 8'hA5 : 8'h00);
      end
      idle(3);

      // Preload, then back-to-back reads from mixed requesters.
      issue(1'b1, 1'b1, 13'h0010, 8'h10, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h00);
      issue(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b1, 13'h0011, 8'h11, 2'b01, 8'h00);
      issue(1'b1, 1'b1, 13'h0012, 8'h12, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h00);
      issue(1'b1, 1'b0, 13'h0010, 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h10);
      issue(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b0, 13'h0011, 8'h00, 2'b01, 8'h11);
      issue(1'b1, 1'b0, 13'h0012, 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h12);
      // Pointer now favours B on a tie.
      issue(1'b1, 1'b0, 13'h0010, 8'h00, 1'b1, 1'b0, 13'h0011, 8'h00, 2'b01, 8'h11);
      issue(1'b1, 1'b0, 13'h0010, 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h10);
      // Last address written by B, read by A.
      issue(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1, 1'b1, 13'h1FFF, 8'h5A, 2'b01, 8'h00);
      issue(1'b1, 1'b0, 13'h1FFF, 8'h00, 1'b0, 1'b0, 13'h0000, 8'h00, 2'b10, 8'h5A);
      idle(4);

      chk("sb_drain_lat1", q1.size(), 32'd0);
      chk("sb_drain_lat2", q2.size(), 32'd0);

      // Reset lands in the cycle after a read accept: the response must vanish.
      a_valid = 1'b1; a_we = 1'b0; a_addr = 13'h0010;
      b_valid = 1'b0;
      #1;
      chk("inflight_grant", {30'd0, d1_a_ready, d2_a_ready}, 32'd3);
      @(posedge clk);
      #1;
      rst_n   = 1'b0;
      a_valid = 1'b0;
      seen    = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) rst_n = 1'b1;
         step();
         seen += int'(d1_a_rsp) + int'(d1_b_rsp) + int'(d2_a_rsp) + int'(d2_b_rsp);
      end
      chk("inflight_dropped", seen, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bsram_arbiter.md
Name: bsram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the 8K x 8 single-port block RAM wrapper (ports clk, ce, oce, reset, wre, ad[12:0], din[7:0], dout[7:0]).
- After reset it zero-fills the whole RAM.
- It then grants at most one read or write per cycle to requester A or B.
- Read data is routed back to the requester that issued the read, after the RAM's fixed read latency.
- Sits between two bus masters (e.g. CPU port and DMA/UART port) and the RAM instance.

Parameters:
- ADDR_W, 13, RAM address width; DEPTH = 2**ADDR_W.
- DATA_W, 8, RAM data width.
- RD_LAT, 1, RAM read latency in cycles. 1 = bypass read mode; 2 = pipeline read mode. Only 1 and 2 are legal.
- CLEAR_ON_RESET, 1, 1 = zero-fill the RAM after reset before accepting requests; 0 = go straight to RUN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- a_valid  in  1  requester A command valid
- a_ready  out  1  requester A command accepted this cycle
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  requester A address
- a_wdata  in  DATA_W  requester A write data
- a_rsp_valid  out  1  read data for A valid
- a_rdata  out  DATA_W  read data for A
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rsp_valid, b_rdata: same as the A ports, for requester B
- init_done  out  1  clear sweep finished; arbiter accepting requests
- mem_ce  out  1  RAM clock enable
- mem_oce  out  1  RAM output-register enable
- mem_reset  out  1  RAM reset (active-high)
- mem_wre  out  1  RAM write enable
- mem_ad  out  ADDR_W  RAM address
- mem_din  out  DATA_W  RAM write data
- mem_dout  in  DATA_W  RAM read data

Behaviour:
- Clocking and reset: one clock domain; all state updates on the rising edge of clk.
- While rst_n = 0, on the next edge:
  - state <= CLEAR if CLEAR_ON_RESET, else RUN.
  - clr_cnt <= 0; rr_ptr <= A; read-tag pipeline cleared.
- Outputs while rst_n = 0: a_ready = b_ready = 0, rsp_valid = 0, init_done = 0, mem_ce = mem_wre = 0, mem_reset = 1.
- mem_oce is tied to 1; mem_reset = ~rst_n.
- State CLEAR:
  - Each cycle: mem_ce = 1, mem_wre = 1, mem_ad = clr_cnt, mem_din = 0; clr_cnt increments.
  - When clr_cnt = DEPTH-1 is written, next state is RUN.
  - Both ready outputs are 0; requesters simply wait with valid held.
  - The sweep lasts exactly DEPTH cycles (8192 by default).
- State RUN: init_done = 1. Grant is combinational in the same cycle:
  - Only one valid: that requester is granted.
  - Both valid: the requester equal to rr_ptr is granted.
  - Neither valid: mem_ce = 0.
- On a grant:
  - The granted requester's ready = 1 and the other's ready = 0.
  - mem_ce = 1; mem_wre, mem_ad and mem_din are taken from the granted requester.
  - rr_ptr <= the non-granted requester (it updates on every grant).
- Handshake rules:
  - A transfer occurs when valid and ready are both 1.
  - The requester holds valid, we, addr and wdata stable until ready.
  - valid must not depend combinationally on ready.
- Read return:
  - Each accepted read pushes {1, id} into an RD_LAT-deep tag shift register; writes and idle cycles push {0, x}.
  - At the pipeline output, the rsp_valid of the tagged requester is 1 for exactly one cycle.
  - Both rdata outputs are driven from mem_dout directly (valid only when qualified by rsp_valid).
  - Latency from the accept edge to rsp_valid is RD_LAT cycles.
- Throughput: one access per cycle sustained; back-to-back reads from mixed requesters return in issue order.
- Writes: there is no response; the data is visible to a read accepted on any later cycle.
- Boundary cases:
  - Address DEPTH-1: legal.
  - Reset asserted mid-CLEAR: the sweep restarts at 0.
  - Reset asserted with reads in flight: those responses are dropped and never asserted.

Decomposition:
- Shared package: the state enum {CLEAR, RUN}, requester id constants REQ_A = 0 and REQ_B = 1, and a read-tag struct {valid, id}.
- Natural sub-module: rr_arb2, a 2-way round-robin grant with pointer update, 2 valid inputs and 2 grant outputs, plus a pointer register.

Test Plan:
- Reset with CLEAR_ON_RESET = 1 -> init_done rises exactly 8192 cycles after rst_n goes high; a read of 0x1FFF returns 0x00.
- A writes 0xA5 to 0x0123; B then reads 0x0123 -> b_rsp_valid asserts RD_LAT cycles after accept with b_rdata = 0xA5, and a_rsp_valid stays 0.
- A and B both hold valid reads for 6 cycles -> grants alternate A,B,A,B,A,B; each requester receives 3 responses.
- Reads accepted on consecutive cycles (A@0x10, B@0x11, A@0x12, preloaded with 0x10, 0x11, 0x12) -> one response per cycle, in order, routed correctly; check with RD_LAT = 1 and RD_LAT = 2.
- rst_n pulsed low at clear count 100 -> the sweep restarts at address 0 and still takes the full 8192 cycles.
- rst_n pulsed low one cycle after a read accept -> no rsp_valid is asserted for that read.
